// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for an 8-bit subtractive-Euclid GCD datapath.
//
// The controller loads operands A and B into register-file slots 0 and 1.
// It reads both back through the datapath, compares them internally and
// subtracts the smaller from the larger. It repeats until the operands are
// equal or one of them is zero. It then routes the surviving slot to the
// datapath output for one cycle, pulsing done.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-high reset
//   start   in   1   begin operation (sampled only in IDLE)
//   status  in   8   datapath shifter output (combinational feedback)
//   cw      out  16  datapath control word
//                    {input_en, WE, WA[1:0], RAE, RAA[1:0], RBE, RBA[1:0],
//                     alu_sel[2:0], sh[1:0], output_en}
//   req_a   out  1   environment must present operand A on datapath din
//   req_b   out  1   environment must present operand B on datapath din
//   busy    out  1   high in every state except IDLE
//   done    out  1   one-cycle pulse; datapath dout valid in that cycle
//   err     out  1   both-zero operands or iteration overflow (registered)
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  status,
  output logic [15:0] cw,
  output logic        req_a,
  output logic        req_b,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] ALU_PASS   = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [1:0] SH_NONE    = 2'b00;
  localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_RD_A   = 4'd3,
    S_RD_B   = 4'd4,
    S_CMP    = 4'd5,
    S_SUB_AB = 4'd6,
    S_SUB_BA = 4'd7,
    S_OUT    = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [7:0] iter_q, iter_d;
  logic       err_q, err_d;
  logic       sel_q, sel_d;  // register-file slot read out in OUT

  // Assemble a control word from its individual fields.
  function automatic logic [15:0] pack_cw(
    input logic       in_en,
    input logic       we,
    input logic [1:0] wa,
    input logic       rae,
    input logic [1:0] raa,
    input logic       rbe,
    input logic [1:0] rba,
    input logic [2:0] alu,
    input logic [1:0] sh,
    input logic       out_en
  );
    return {in_en, we, wa, rae, raa, rbe, rba, alu, sh, out_en};
  endfunction

  // State and datapath-shadow registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      iter_q  <= 8'h00;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic and register updates.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    iter_d  = iter_q;
    err_d   = err_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          iter_d  = 8'h00;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_RD_A;
      S_RD_A: begin
        opa_d   = status;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        opb_d   = status;
        state_d = S_CMP;
      end
      S_CMP: begin
        // Exits are checked before the subtract decision so that a zero
        // operand never enters the subtract loop.
        if ((opa_q == 8'h00) && (opb_q == 8'h00)) begin
          err_d   = 1'b1;
          sel_d   = 1'b0;
          state_d = S_OUT;
        end else if (opb_q == 8'h00) begin
          sel_d   = 1'b0;
          state_d = S_OUT;
        end else if (opa_q == 8'h00) begin
          sel_d   = 1'b1;
          state_d = S_OUT;
        end else if (opa_q == opb_q) begin
          sel_d   = 1'b0;
          state_d = S_OUT;
        end else if (iter_q == MAX_ITER_C) begin
          err_d   = 1'b1;
          sel_d   = 1'b0;
          state_d = S_OUT;
        end else if (opa_q > opb_q) begin
          state_d = S_SUB_AB;
        end else begin
          state_d = S_SUB_BA;
        end
      end
      S_SUB_AB, S_SUB_BA: begin
        iter_d  = iter_q + 8'd1;
        state_d = S_RD_A;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    cw    = 16'h0000;
    req_a = 1'b0;
    req_b = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_LOAD_A: begin
        cw    = pack_cw(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, ALU_PASS, SH_NONE, 1'b0);
        req_a = 1'b1;
      end
      S_LOAD_B: begin
        cw    = pack_cw(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, ALU_PASS, SH_NONE, 1'b0);
        req_b = 1'b1;
      end
      S_RD_A:   cw = pack_cw(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, ALU_PASS, SH_NONE, 1'b0);
      S_RD_B:   cw = pack_cw(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, ALU_PASS, SH_NONE, 1'b0);
      S_CMP:    cw = 16'h0000;
      // Larger operand on port A, result written back over the larger one.
      S_SUB_AB: cw = pack_cw(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 2'd1, ALU_SUB, SH_NONE, 1'b0);
      S_SUB_BA: cw = pack_cw(1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 2'd0, ALU_SUB, SH_NONE, 1'b0);
      S_OUT: begin
        cw   = pack_cw(1'b0, 1'b0, 2'd0, 1'b1, {1'b0, sel_q}, 1'b0, 2'd0, ALU_PASS, SH_NONE, 1'b1);
        done = 1'b1;
      end
      default: begin
        cw   = 16'h0000;
        busy = 1'b0;
      end
    endcase
  end

  assign err = err_q;

endmodule
